// File: rtl/warp_diverge_stack_if.sv
// Branch/fetch/mask-update signal bundle for warp_diverge_stack.
// master = the divergence controller, slave = the environment around it.
interface warp_diverge_stack_if #(
  parameter int NUM_LANES = 8,
  parameter int DEPTH     = 4,
  parameter int PC_W      = 16
);
  localparam int DW = $clog2(DEPTH + 1);

  // Branch handshake: a branch transfers on a cycle where br_valid && br_ready.
  // br_taken/br_target/br_fallthru/br_reconv are only meaningful while br_valid.
  logic [NUM_LANES-1:0] cur_mask;
  logic                 br_valid;
  logic                 br_ready;
  logic [NUM_LANES-1:0] br_taken;
  logic [PC_W-1:0]      br_target;
  logic [PC_W-1:0]      br_fallthru;
  logic [PC_W-1:0]      br_reconv;
  logic                 pc_valid;
  logic [PC_W-1:0]      pc;
  logic                 mask_update;
  logic [NUM_LANES-1:0] mask_in;
  logic                 redirect_valid;
  logic [PC_W-1:0]      redirect_pc;
  logic [DW-1:0]        depth;
  logic                 full;
  logic [1:0]           dbg_state;

  modport master (
    input  cur_mask, br_valid, br_taken, br_target, br_fallthru, br_reconv,
           pc_valid, pc,
    output br_ready, mask_update, mask_in, redirect_valid, redirect_pc,
           depth, full, dbg_state
  );

  modport slave (
    output cur_mask, br_valid, br_taken, br_target, br_fallthru, br_reconv,
           pc_valid, pc,
    input  br_ready, mask_update, mask_in, redirect_valid, redirect_pc,
           depth, full, dbg_state
  );
endinterface

// File: rtl/warp_diverge_stack.sv
// SIMT divergence/reconvergence stack: narrows the warp mask on divergent
// branches and walks then -> else -> full mask at the reconvergence PC.
module warp_diverge_stack #(
  parameter int NUM_LANES = 8,
  parameter int DEPTH     = 4,
  parameter int PC_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  warp_diverge_stack_if.master bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PULSE = 2'd1,
    WAIT_LATCH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]      ent_reconv [DEPTH];
  logic [NUM_LANES-1:0] ent_full   [DEPTH];
  logic [NUM_LANES-1:0] ent_emask  [DEPTH];
  logic [PC_W-1:0]      ent_epc    [DEPTH];
  logic                 ent_else   [DEPTH];

  logic [DW-1:0]        depth_q;
  logic                 mask_update_q, redirect_valid_q;
  logic [NUM_LANES-1:0] mask_in_q;
  logic [PC_W-1:0]      redirect_pc_q;

  logic [IW-1:0]        push_idx, top_idx;
  logic                 full_w, hit, ready_w, accept;
  logic [NUM_LANES-1:0] t_mask, n_mask;

  logic                 do_push, do_pop, do_else;
  logic                 mu_nxt, rv_nxt;
  logic [NUM_LANES-1:0] mi_nxt;
  logic [PC_W-1:0]      rp_nxt;

  assign push_idx = IW'(depth_q);
  assign top_idx  = IW'(depth_q - DW'(1));
  assign full_w   = (depth_q == DW'(DEPTH));
  // Hit detection is only live in IDLE so WAIT hides a stale cur_mask/pc.
  assign hit      = (state == IDLE) && bus.pc_valid && (depth_q != '0) &&
                    (bus.pc == ent_reconv[top_idx]);
  assign ready_w  = (state == IDLE) && !full_w && !hit;
  assign accept   = bus.br_valid && ready_w;
  assign t_mask   = bus.br_taken & bus.cur_mask;
  assign n_mask   = ~bus.br_taken & bus.cur_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_else   = 1'b0;
    mu_nxt    = 1'b0;
    rv_nxt    = 1'b0;
    mi_nxt    = mask_in_q;
    rp_nxt    = redirect_pc_q;
    case (state)
      IDLE: begin
        if (hit) begin
          mu_nxt    = 1'b1;
          state_nxt = WAIT_PULSE;
          if (ent_else[top_idx]) begin
            do_pop = 1'b1;
            mi_nxt = ent_full[top_idx];
          end else begin
            do_else = 1'b1;
            mi_nxt  = ent_emask[top_idx];
            rv_nxt  = 1'b1;
            rp_nxt  = ent_epc[top_idx];
          end
        end else if (accept) begin
          rv_nxt = 1'b1;
          if (t_mask != '0 && n_mask != '0) begin
            do_push   = 1'b1;
            mu_nxt    = 1'b1;
            mi_nxt    = t_mask;
            rp_nxt    = bus.br_target;
            state_nxt = WAIT_PULSE;
          end else if (t_mask != '0) begin
            rp_nxt = bus.br_target;
          end else begin
            rp_nxt = bus.br_fallthru;
          end
        end
      end
      WAIT_PULSE: state_nxt = WAIT_LATCH;
      WAIT_LATCH: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q          <= '0;
      mask_update_q    <= 1'b0;
      mask_in_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reconv[i] <= '0;
        ent_full[i]   <= '0;
        ent_emask[i]  <= '0;
        ent_epc[i]    <= '0;
        ent_else[i]   <= 1'b0;
      end
    end else begin
      mask_update_q    <= mu_nxt;
      mask_in_q        <= mi_nxt;
      redirect_valid_q <= rv_nxt;
      redirect_pc_q    <= rp_nxt;
      if (do_push) begin
        ent_reconv[push_idx] <= bus.br_reconv;
        ent_full[push_idx]   <= bus.cur_mask;
        ent_emask[push_idx]  <= n_mask;
        ent_epc[push_idx]    <= bus.br_fallthru;
        ent_else[push_idx]   <= 1'b0;
        depth_q              <= depth_q + DW'(1);
      end
      if (do_else) ent_else[top_idx] <= 1'b1;
      if (do_pop) begin
        ent_else[top_idx] <= 1'b0;
        depth_q           <= depth_q - DW'(1);
      end
    end
  end

  assign bus.br_ready       = ready_w;
  assign bus.mask_update    = mask_update_q;
  assign bus.mask_in        = mask_in_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.depth          = depth_q;
  assign bus.full           = full_w;
  assign bus.dbg_state      = state;
endmodule

// File: tb/tb_warp_diverge_stack.sv
// Directed bench for warp_diverge_stack with a small warp_mask model that
// latches mask_in on mask_update, feeding cur_mask back to the DUT.
module tb_warp_diverge_stack;
  logic clk = 1'b0;
  logic rst;
  int   chk_cnt = 0;
  int   err_cnt = 0;

  logic       force_en;
  logic [7:0] force_mask;
  logic [7:0] wm_mask;

  warp_diverge_stack_if #(.NUM_LANES(8), .DEPTH(4), .PC_W(16)) bus ();

  warp_diverge_stack #(.NUM_LANES(8), .DEPTH(4), .PC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wm_mask <= 8'hFF;
    else if (bus.mask_update) wm_mask <= bus.mask_in;
  end

  assign bus.cur_mask = force_en ? force_mask : wm_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a branch for one edge, then withdraw it.
  task automatic drive_branch(input logic [7:0] taken, input logic [15:0] tgt,
                              input logic [15:0] ft, input logic [15:0] rc);
    bus.br_valid    = 1'b1;
    bus.br_taken    = taken;
    bus.br_target   = tgt;
    bus.br_fallthru = ft;
    bus.br_reconv   = rc;
    #1;
    check("br_ready_accept", {31'd0, bus.br_ready}, 32'd1);
    tick();
    bus.br_valid = 1'b0;
  endtask

  task automatic drive_pc(input logic [15:0] p);
    bus.pc_valid = 1'b1;
    bus.pc       = p;
    #1;
    check("br_ready_hit", {31'd0, bus.br_ready}, 32'd0);
    tick();
    bus.pc_valid = 1'b0;
  endtask

  task automatic settle();
    check("wait_ready0", {31'd0, bus.br_ready}, 32'd0);
    tick();
    check("wait_pulse_off", {31'd0, bus.mask_update}, 32'd0);
    check("wait_ready1", {31'd0, bus.br_ready}, 32'd0);
    tick();
  endtask

  logic [7:0]  nest_taken [4] = '{8'h3F, 8'h0F, 8'h03, 8'h01};
  logic [7:0]  nest_else  [4] = '{8'hC0, 8'h30, 8'h0C, 8'h02};
  logic [7:0]  nest_full  [4] = '{8'hFF, 8'h3F, 8'h0F, 8'h03};
  logic [15:0] nest_rc    [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
  logic [15:0] nest_ft    [4] = '{16'h0110, 16'h0210, 16'h0310, 16'h0410};
  logic [15:0] nest_tgt   [4] = '{16'h0120, 16'h0220, 16'h0320, 16'h0420};

  initial begin
    rst = 1'b1;
    force_en = 1'b0;
    force_mask = 8'h00;
    bus.br_valid = 1'b0;
    bus.br_taken = '0;
    bus.br_target = '0;
    bus.br_fallthru = '0;
    bus.br_reconv = '0;
    bus.pc_valid = 1'b0;
    bus.pc = '0;
    repeat (2) tick();
    check("rst_depth", 32'(bus.depth), 32'd0);
    check("rst_mask_update", {31'd0, bus.mask_update}, 32'd0);
    check("rst_mask_in", 32'(bus.mask_in), 32'd0);
    check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_redirect_pc", 32'(bus.redirect_pc), 32'd0);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, bus.br_ready}, 32'd1);

    // Uniform taken
    drive_branch(8'hFF, 16'h0040, 16'h0010, 16'h0080);
    check("unif_t_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("unif_t_rp", 32'(bus.redirect_pc), 32'h0040);
    check("unif_t_mu", {31'd0, bus.mask_update}, 32'd0);
    check("unif_t_depth", 32'(bus.depth), 32'd0);
    tick();
    check("unif_t_rv_off", {31'd0, bus.redirect_valid}, 32'd0);

    // Divergent then, else, pop
    drive_branch(8'h0F, 16'h0040, 16'h0010, 16'h0080);
    check("div_mu", {31'd0, bus.mask_update}, 32'd1);
    check("div_mi", 32'(bus.mask_in), 32'h0F);
    check("div_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("div_rp", 32'(bus.redirect_pc), 32'h0040);
    check("div_depth", 32'(bus.depth), 32'd1);
    settle();
    check("div_ready_idle", {31'd0, bus.br_ready}, 32'd1);
    drive_pc(16'h0080);
    check("else_mu", {31'd0, bus.mask_update}, 32'd1);
    check("else_mi", 32'(bus.mask_in), 32'hF0);
    check("else_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("else_rp", 32'(bus.redirect_pc), 32'h0010);
    check("else_depth", 32'(bus.depth), 32'd1);
    settle();
    drive_pc(16'h0080);
    check("pop_mu", {31'd0, bus.mask_update}, 32'd1);
    check("pop_mi", 32'(bus.mask_in), 32'hFF);
    check("pop_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("pop_depth", 32'(bus.depth), 32'd0);
    settle();

    // Masked lanes: t == 0 -> uniform not-taken
    force_en = 1'b1;
    force_mask = 8'h3C;
    drive_branch(8'hC3, 16'h0040, 16'h0010, 16'h0080);
    check("mask_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("mask_rp", 32'(bus.redirect_pc), 32'h0010);
    check("mask_mu", {31'd0, bus.mask_update}, 32'd0);
    check("mask_depth", 32'(bus.depth), 32'd0);
    force_en = 1'b0;
    tick();

    // Nest to full
    for (int k = 0; k < 4; k++) begin
      drive_branch(nest_taken[k], nest_tgt[k], nest_ft[k], nest_rc[k]);
      check("nest_mi", 32'(bus.mask_in), 32'(nest_taken[k]));
      check("nest_rp", 32'(bus.redirect_pc), 32'(nest_tgt[k]));
      check("nest_depth", 32'(bus.depth), 32'(k + 1));
      settle();
    end
    check("full_flag", {31'd0, bus.full}, 32'd1);
    bus.br_valid = 1'b1;
    bus.br_taken = 8'h01;
    bus.br_target = 16'h0999;
    #1;
    check("full_ready", {31'd0, bus.br_ready}, 32'd0);
    tick();
    bus.br_valid = 1'b0;
    check("full_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("full_depth", 32'(bus.depth), 32'd4);

    // Unwind in LIFO order
    for (int k = 3; k >= 0; k--) begin
      drive_pc(nest_rc[k]);
      check("unw_else_mi", 32'(bus.mask_in), 32'(nest_else[k]));
      check("unw_else_rp", 32'(bus.redirect_pc), 32'(nest_ft[k]));
      check("unw_else_rv", {31'd0, bus.redirect_valid}, 32'd1);
      settle();
      drive_pc(nest_rc[k]);
      check("unw_pop_mi", 32'(bus.mask_in), 32'(nest_full[k]));
      check("unw_pop_rv", {31'd0, bus.redirect_valid}, 32'd0);
      check("unw_pop_depth", 32'(bus.depth), 32'(k));
      settle();
    end

    // Priority: hit wins over a same-cycle branch
    drive_branch(8'h0F, 16'h0040, 16'h0010, 16'h0080);
    settle();
    bus.br_valid = 1'b1;
    bus.br_taken = 8'h0F;
    bus.br_target = 16'h0500;
    bus.br_fallthru = 16'h0600;
    bus.br_reconv = 16'h0700;
    drive_pc(16'h0080);
    check("prio_mu", {31'd0, bus.mask_update}, 32'd1);
    check("prio_mi", 32'(bus.mask_in), 32'hF0);
    check("prio_rp", 32'(bus.redirect_pc), 32'h0010);
    settle();
    #1;
    check("prio_ready_after", {31'd0, bus.br_ready}, 32'd1);
    tick();
    bus.br_valid = 1'b0;
    check("prio_br_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("prio_br_rp", 32'(bus.redirect_pc), 32'h0600);
    check("prio_br_mu", {31'd0, bus.mask_update}, 32'd0);
    check("prio_br_depth", 32'(bus.depth), 32'd1);
    tick();

    // Reset in the middle of WAIT with depth 2
    drive_branch(8'h30, 16'h0800, 16'h0810, 16'h0820);
    check("pre_rst_depth", 32'(bus.depth), 32'd2);
    rst = 1'b1;
    #1;
    check("arst_depth", 32'(bus.depth), 32'd0);
    check("arst_mu", {31'd0, bus.mask_update}, 32'd0);
    check("arst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("arst_full", {31'd0, bus.full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.br_ready}, 32'd1);
    tick();
    check("arst_ready_later", {31'd0, bus.br_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
